// File: rtl/add_pipe_if.sv
// Operand request and result channels of add_pipe.
// Both channels are valid/ready: a transfer happens on a rising edge where valid and ready are both high,
// and a producer that raises valid keeps its payload stable until that edge.
interface add_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/add_pipe.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES registered CHUNK-bit segments,
// with operand skew and result deskew shift registers, and a single global stall enable.
module add_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic       clk,
    input logic       rst_n,
    add_pipe_if.slave bus
);
    localparam int CHUNK = (STAGES >= 1 && WIDTH >= STAGES) ? WIDTH / STAGES : 1;

    if (STAGES < 1 || WIDTH < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("add_pipe: STAGES must be >= 1 and divide WIDTH");
    end

    logic              adv;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] carry;
    logic [WIDTH-1:0]  s_all;
    logic              ovf_w;

    // Whole pipe moves together: it advances whenever the output slot is empty or being drained.
    assign adv           = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.s         = s_all;
    assign bus.cout      = carry[STAGES-1];
    assign bus.ovf       = ovf_w;

    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub ? 1'b1 : bus.cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q[0] <= bus.in_valid;
            for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_chunk
        localparam int DEPTH = STAGES - j;

        logic [CHUNK-1:0] op_a;
        logic [CHUNK-1:0] op_b;
        logic             c_in;
        logic [CHUNK:0]   part;
        logic             c_q;
        logic [CHUNK-1:0] res_q [DEPTH];

        if (j == 0) begin : g_first
            assign op_a = bus.a[CHUNK-1:0];
            assign op_b = b_eff[CHUNK-1:0];
            assign c_in = c0;
        end else begin : g_skew
            // Chunk j waits j cycles so it meets the carry rippling up from chunk j-1.
            logic [CHUNK-1:0] a_sk [j];
            logic [CHUNK-1:0] b_sk [j];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < j; i++) begin
                        a_sk[i] <= '0;
                        b_sk[i] <= '0;
                    end
                end else if (adv) begin
                    a_sk[0] <= bus.a[j*CHUNK +: CHUNK];
                    b_sk[0] <= b_eff[j*CHUNK +: CHUNK];
                    for (int i = 1; i < j; i++) begin
                        a_sk[i] <= a_sk[i-1];
                        b_sk[i] <= b_sk[i-1];
                    end
                end
            end

            assign op_a = a_sk[j-1];
            assign op_b = b_sk[j-1];
            assign c_in = carry[j-1];
        end

        assign part = {1'b0, op_a} + {1'b0, op_b} + {{CHUNK{1'b0}}, c_in};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c_q <= 1'b0;
                for (int i = 0; i < DEPTH; i++) res_q[i] <= '0;
            end else if (adv) begin
                c_q      <= part[CHUNK];
                res_q[0] <= part[CHUNK-1:0];
                for (int i = 1; i < DEPTH; i++) res_q[i] <= res_q[i-1];
            end
        end

        assign carry[j]                 = c_q;
        assign s_all[j*CHUNK +: CHUNK] = res_q[DEPTH-1];

        if (j == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (op_a[CHUNK-1] == op_b[CHUNK-1]) && (part[CHUNK-1] != op_a[CHUNK-1]);
                end
            end

            assign ovf_w = ovf_q;
        end
    end
endmodule
